// File: rtl/cu_sequencer.sv
// -----------------------------------------------------------------------------
// cu_sequencer
//
// Top-level multi-cycle control sequencer for the ARM-style datapath. Owns the
// state register, the instruction fetch cycle and the {V,C,N,Z} status
// register. After a fetch it decodes the instruction class from IR and
// forwards the matching sub-unit's controlWord / k_mux / next-state request.
// Memory wait states hold the sequencer, and illegal classes, bad next-state
// requests or over-long stalls drop it into an absorbing FAULT state.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-low reset
//   IR           instruction register contents from the datapath
//   status_in    {V,C,N,Z} produced by the ALU this cycle
//   mem_ready    memory access completes this cycle
//   cw_br/dp/ls  controlWord from branch / data-processing / load-store units
//   ns_br/dp/ls  next-state request from each sub-unit
//   km_br/dp/ls  k_mux from each sub-unit
//   state        current state, fed to all sub-units
//   status       registered {V,C,N,Z}, fed to all sub-units
//   controlWord  controlWord applied to the datapath
//   k_mux        constant mux select
//   retire       one-cycle pulse in the FETCH cycle after an instruction ends
//   fault        sticky fault flag
// -----------------------------------------------------------------------------
module cu_sequencer #(
   parameter int CUL     = 36,
   parameter int TIMEOUT = 15
) (
   input  logic           clock,
   input  logic           reset,
   input  logic [31:0]    IR,
   input  logic [3:0]     status_in,
   input  logic           mem_ready,
   input  logic [CUL:0]   cw_br,
   input  logic [CUL:0]   cw_dp,
   input  logic [CUL:0]   cw_ls,
   input  logic [3:0]     ns_br,
   input  logic [3:0]     ns_dp,
   input  logic [3:0]     ns_ls,
   input  logic [2:0]     km_br,
   input  logic [2:0]     km_dp,
   input  logic [2:0]     km_ls,
   output logic [3:0]     state,
   output logic [3:0]     status,
   output logic [CUL:0]   controlWord,
   output logic [2:0]     k_mux,
   output logic           retire,
   output logic           fault
);

   // controlWord field positions (LSB first)
   localparam int B_PC_FS      = 0;   // [1:0]
   localparam int B_PC_SEL     = 2;
   localparam int B_DATA_TRI   = 3;   // [4:3]
   localparam int B_SIZE       = 6;   // [7:6]
   localparam int B_STATUS_LD  = 8;
   localparam int B_IR_LOAD    = 9;
   localparam int B_MEM_WE     = 10;
   localparam int B_MEM_CS     = 12;  // [13:12]
   localparam int B_W_REG      = 15;

   localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

   typedef enum logic [3:0] {
      ST_FETCH = 4'b0000,
      ST_EX0   = 4'b0001,
      ST_EX1   = 4'b0010,
      ST_EX2   = 4'b0011,
      ST_FAULT = 4'b1111
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    status_q, status_d;
   logic [3:0]    stall_cnt_q, stall_cnt_d;
   logic          fault_q, fault_d;
   logic          retire_q, retire_d;

   logic          is_br, is_ls, is_dp, legal;
   logic [CUL:0]  sel_cw;
   logic [3:0]    sel_ns;
   logic [2:0]    sel_km;
   logic [CUL:0]  cw_out;
   logic [2:0]    km_out;

   // Only IR[28:25] takes part in class decode.
   logic          unused_ir;
   assign unused_ir = ^{IR[31:29], IR[24:0]};

   // Fixed word driven during instruction fetch: read memory (mem_cs=01,
   // size=11), steer the data bus into IR and advance the PC.
   function automatic logic [CUL:0] fetch_word();
      logic [CUL:0] w;
      w                        = '0;
      w[B_PC_FS +: 2]          = 2'b01;
      w[B_PC_SEL]              = 1'b1;
      w[B_DATA_TRI +: 2]       = 2'b01;
      w[B_SIZE +: 2]           = 2'b11;
      w[B_IR_LOAD]             = 1'b1;
      w[B_MEM_CS +: 2]         = 2'b01;
      return w;
   endfunction

   // While memory is not ready, suppress every architectural side effect so
   // the stalled cycle can be replayed unchanged.
   function automatic logic [CUL:0] stall_gate(input logic [CUL:0] cw);
      logic [CUL:0] w;
      w                = cw;
      w[B_W_REG]       = 1'b0;
      w[B_STATUS_LD]   = 1'b0;
      w[B_IR_LOAD]     = 1'b0;
      w[B_MEM_WE]      = 1'b0;
      w[B_PC_FS +: 2]  = 2'b00;
      return w;
   endfunction

   // Instruction class decode and sub-unit selection. The three class
   // patterns are mutually exclusive, so the priority order is immaterial.
   always_comb begin
      is_br  = (IR[28:26] == 3'b101);
      is_ls  = IR[27] && !IR[25];
      is_dp  = (IR[27:26] == 2'b00) && IR[28];
      legal  = 1'b1;
      sel_cw = '0;
      sel_ns = 4'b0000;
      sel_km = 3'b000;
      if (is_br) begin
         sel_cw = cw_br;
         sel_ns = ns_br;
         sel_km = km_br;
      end else if (is_ls) begin
         sel_cw = cw_ls;
         sel_ns = ns_ls;
         sel_km = km_ls;
      end else if (is_dp) begin
         sel_cw = cw_dp;
         sel_ns = ns_dp;
         sel_km = km_dp;
      end else begin
         legal = 1'b0;
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d     = state_q;
      stall_cnt_d = 4'd0;
      retire_d    = 1'b0;
      cw_out      = '0;
      km_out      = 3'b000;

      case (state_q)
         ST_FETCH: begin
            cw_out = fetch_word();
            if (!mem_ready) begin
               cw_out = stall_gate(cw_out);
               if (stall_cnt_q == TIMEOUT_CNT) begin
                  state_d     = ST_FAULT;
                  stall_cnt_d = stall_cnt_q;
               end else begin
                  stall_cnt_d = stall_cnt_q + 4'd1;
               end
            end else begin
               state_d = ST_EX0;
            end
         end

         ST_EX0, ST_EX1, ST_EX2: begin
            // IR is stable through EX, so an illegal class is trapped on the
            // first EX cycle; later EX states inherit the same guard.
            if (!legal) begin
               state_d = ST_FAULT;
            end else begin
               cw_out      = sel_cw;
               cw_out[CUL] = 1'b0;
               km_out      = sel_km;
               // A pending access outranks the sub-unit's next-state request,
               // including a request to finish (no retire until it lands).
               if ((sel_cw[B_MEM_CS +: 2] != 2'b00) && !mem_ready) begin
                  cw_out = stall_gate(cw_out);
                  if (stall_cnt_q == TIMEOUT_CNT) begin
                     state_d     = ST_FAULT;
                     stall_cnt_d = stall_cnt_q;
                  end else begin
                     stall_cnt_d = stall_cnt_q + 4'd1;
                  end
               end else begin
                  case (sel_ns)
                     4'b0000: begin
                        state_d  = ST_FETCH;
                        retire_d = 1'b1;
                     end
                     4'b0001: state_d = ST_EX0;
                     4'b0010: state_d = ST_EX1;
                     4'b0011: state_d = ST_EX2;
                     default: state_d = ST_FAULT;
                  endcase
               end
            end
         end

         ST_FAULT: begin
            state_d = ST_FAULT;
         end

         default: begin
            state_d = ST_FAULT;
         end
      endcase

      fault_d  = fault_q || (state_d == ST_FAULT);
      status_d = cw_out[B_STATUS_LD] ? status_in : status_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_FETCH;
         status_q    <= 4'b0000;
         stall_cnt_q <= 4'd0;
         fault_q     <= 1'b0;
         retire_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         status_q    <= status_d;
         stall_cnt_q <= stall_cnt_d;
         fault_q     <= fault_d;
         retire_q    <= retire_d;
      end
   end

   assign state       = state_q;
   assign status      = status_q;
   assign controlWord = cw_out;
   assign k_mux       = km_out;
   assign retire      = retire_q;
   assign fault       = fault_q;

endmodule

// File: tb/tb_cu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cu_sequencer
//
// Directed bench for cu_sequencer: fetch, branch, multi-state branch with a
// status load, stalled load, FETCH stall timeout, illegal class and
// asynchronous reset. Inputs change #1 after the rising edge; outputs are
// sampled a further #1 later.
// -----------------------------------------------------------------------------
module tb_cu_sequencer;

   localparam int CUL = 36;

   logic           clock;
   logic           reset;
   logic [31:0]    IR;
   logic [3:0]     status_in;
   logic           mem_ready;
   logic [CUL:0]   cw_br, cw_dp, cw_ls;
   logic [3:0]     ns_br, ns_dp, ns_ls;
   logic [2:0]     km_br, km_dp, km_ls;
   logic [3:0]     state;
   logic [3:0]     status;
   logic [CUL:0]   controlWord;
   logic [2:0]     k_mux;
   logic           retire;
   logic           fault;

   int n_total = 0;
   int n_bad   = 0;

   // Expected fetch words: 0x12CD when memory is ready, 0x10CC when stalled
   // (PC_FS and IR_load dropped).
   localparam logic [CUL:0] CW_FETCH       = 37'h0_0000_12CD;
   localparam logic [CUL:0] CW_FETCH_STALL = 37'h0_0000_10CC;

   cu_sequencer #(.CUL(CUL), .TIMEOUT(15)) dut (
      .clock       (clock),
      .reset       (reset),
      .IR          (IR),
      .status_in   (status_in),
      .mem_ready   (mem_ready),
      .cw_br       (cw_br),
      .cw_dp       (cw_dp),
      .cw_ls       (cw_ls),
      .ns_br       (ns_br),
      .ns_dp       (ns_dp),
      .ns_ls       (ns_ls),
      .km_br       (km_br),
      .km_dp       (km_dp),
      .km_ls       (km_ls),
      .state       (state),
      .status      (status),
      .controlWord (controlWord),
      .k_mux       (k_mux),
      .retire      (retire),
      .fault       (fault)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset     = 1'b0;
      IR        = 32'h1400_0004;
      status_in = 4'b0000;
      mem_ready = 1'b0;
      cw_br     = 37'h10_0000_8001;  // bit 36 set on purpose: must be masked
      cw_dp     = 37'h0_0000_0000;
      cw_ls     = 37'h0_0000_0000;
      ns_br     = 4'b0000;
      ns_dp     = 4'b0000;
      ns_ls     = 4'b0000;
      km_br     = 3'b010;
      km_dp     = 3'b000;
      km_ls     = 3'b000;

      // ---- reset state ----
      #2;
      check_eq("rst_state",  state, 4'b0000);
      check_eq("rst_status", status, 4'b0000);
      check_eq("rst_fault",  fault, 1'b0);
      check_eq("rst_retire", retire, 1'b0);
      check_eq("rst_cw_stall", controlWord, CW_FETCH_STALL);
      check_eq("rst_kmux",   k_mux, 3'b000);

      // ---- fetch with mem_ready, then branch B (ns_br=0000) ----
      mem_ready = 1'b1;
      #10;
      reset = 1'b1;               // t=12, rising edges at 5,15,25,...
      #1;
      check_eq("fetch_cw",    controlWord, CW_FETCH);
      check_eq("fetch_state", state, 4'b0000);

      next_cycle();               // EX0
      check_eq("b_ex0_state", state, 4'b0001);
      check_eq("b_ex0_kmux",  k_mux, 3'b010);
      check_eq("b_ex0_cw",    controlWord, 37'h0_0000_8001);
      check_eq("b_ex0_retire", retire, 1'b0);

      next_cycle();               // back in FETCH
      check_eq("b_fetch_state",  state, 4'b0000);
      check_eq("b_fetch_retire", retire, 1'b1);
      check_eq("b_status_hold",  status, 4'b0000);

      // ---- CBZ: EX0 loads status, visits EX1, retires ----
      IR        = 32'hB400_0040;
      ns_br     = 4'b0010;
      cw_br     = 37'h0_0000_0100;   // status_load only
      km_br     = 3'b000;
      status_in = 4'b0001;
      next_cycle();               // EX0
      check_eq("cbz_ex0_state", state, 4'b0001);
      check_eq("cbz_ex0_retire", retire, 1'b0);
      check_eq("cbz_ex0_cw",    controlWord, 37'h0_0000_0100);

      next_cycle();               // EX1
      check_eq("cbz_ex1_state", state, 4'b0010);
      check_eq("cbz_status",    status, 4'b0001);
      ns_br     = 4'b0000;
      cw_br     = 37'h0_0000_0000;
      status_in = 4'b0000;

      next_cycle();               // FETCH
      check_eq("cbz_fetch_state", state, 4'b0000);
      check_eq("cbz_retire",      retire, 1'b1);
      check_eq("cbz_status_keep", status, 4'b0001);

      // ---- LDUR with three memory wait states ----
      IR    = 32'hF840_0000;
      cw_ls = 37'h0_0000_9101;       // mem_cs=01, w_reg, status_load, PC_FS=01
      ns_ls = 4'b0000;
      km_ls = 3'b101;
      status_in = 4'b1010;
      next_cycle();               // EX0
      mem_ready = 1'b0;
      #1;
      check_eq("ld_stall_cw",   controlWord, 37'h0_0000_1000);
      check_eq("ld_stall_kmux", k_mux, 3'b101);
      for (int i = 1; i <= 3; i++) begin
         next_cycle();
         check_eq("ld_hold_state", state, 4'b0001);
         check_eq("ld_hold_retire", retire, 1'b0);
         check_eq("ld_stall_cnt", dut.stall_cnt_q, i);
      end
      check_eq("ld_status_gated", status, 4'b0001);
      mem_ready = 1'b1;
      #1;
      check_eq("ld_ready_cw", controlWord, 37'h0_0000_9101);
      next_cycle();               // FETCH
      check_eq("ld_done_state",  state, 4'b0000);
      check_eq("ld_done_retire", retire, 1'b1);
      check_eq("ld_cnt_clear",   dut.stall_cnt_q, 0);
      check_eq("ld_status",      status, 4'b1010);

      // ---- FETCH stall timeout ----
      mem_ready = 1'b0;
      for (int i = 1; i <= 15; i++) begin
         next_cycle();
      end
      check_eq("to_state_15",  state, 4'b0000);
      check_eq("to_fault_15",  fault, 1'b0);
      check_eq("to_cw_15",     controlWord, CW_FETCH_STALL);
      next_cycle();               // 16th stalled cycle ends in FAULT
      check_eq("to_state", state, 4'b1111);
      check_eq("to_fault", fault, 1'b1);
      check_eq("to_cw",    controlWord, 37'h0);
      check_eq("to_kmux",  k_mux, 3'b000);
      mem_ready = 1'b1;
      next_cycle();
      next_cycle();
      check_eq("to_absorb_state", state, 4'b1111);
      check_eq("to_absorb_fault", fault, 1'b1);

      // ---- async reset out of FAULT ----
      #2;
      reset = 1'b0;
      #1;
      check_eq("arst_state",  state, 4'b0000);
      check_eq("arst_fault",  fault, 1'b0);
      check_eq("arst_status", status, 4'b0000);
      #1;
      reset = 1'b1;

      // ---- illegal class IR=0 ----
      IR = 32'h0000_0000;
      next_cycle();               // EX0
      check_eq("ill_ex0_state", state, 4'b0001);
      check_eq("ill_ex0_cw",    controlWord, 37'h0);
      next_cycle();
      check_eq("ill_state", state, 4'b1111);
      check_eq("ill_fault", fault, 1'b1);

      // ---- reset mid-EX1 ----
      #2;
      reset = 1'b0;
      #2;
      reset = 1'b1;
      IR        = 32'hB400_0040;
      ns_br     = 4'b0010;
      cw_br     = 37'h0_0000_0100;
      status_in = 4'b0110;
      next_cycle();               // EX0
      check_eq("mid_ex0_state", state, 4'b0001);
      next_cycle();               // EX1
      check_eq("mid_ex1_state", state, 4'b0010);
      check_eq("mid_status",    status, 4'b0110);
      #2;
      reset = 1'b0;
      #1;
      check_eq("mid_rst_state",  state, 4'b0000);
      check_eq("mid_rst_status", status, 4'b0000);
      check_eq("mid_rst_fault",  fault, 1'b0);
      check_eq("mid_rst_retire", retire, 1'b0);
      #1;
      reset = 1'b1;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
